// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: opcode, funct and field constants plus exception codes for the fetch and decode stages
package cpu_isa_pkg;
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2a;
  localparam logic [5:0] FN_SLTU    = 6'h2b;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;
  localparam int EXC_NONE = 0;
  localparam int EXC_ADEL = 4;
  localparam int EXC_RI   = 10;
endpackage

// File: rtl/id_fetch_buffer_if.sv
// id_fetch_buffer_if: fetch-side push channel and decode-side head view of the IF/ID buffer
interface id_fetch_buffer_if #(
  parameter int IW = 32,
  parameter int PW = 32,
  parameter int EXW = 5,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [IW-1:0] in_instr;
  logic [PW-1:0] in_pc;
  logic in_bd;
  logic [EXW-1:0] in_excode;
  logic out_valid;
  logic out_ready;
  logic [IW-1:0] IR_D;
  logic [PW-1:0] PC_D;
  logic [PW-1:0] PC4_D;
  logic [PW-1:0] PC8_D;
  logic BD_D;
  logic [EXW-1:0] excode_D;
  logic [CW-1:0] count;
  modport master (
    output flush, in_valid, in_instr, in_pc, in_bd, in_excode, out_ready,
    input  in_ready, out_valid, IR_D, PC_D, PC4_D, PC8_D, BD_D, excode_D, count
  );
  modport slave (
    input  flush, in_valid, in_instr, in_pc, in_bd, in_excode, out_ready,
    output in_ready, out_valid, IR_D, PC_D, PC4_D, PC8_D, BD_D, excode_D, count
  );
endinterface

// File: rtl/ri_decode.sv
// ri_decode: flags any instruction outside the supported subset as reserved
module ri_decode
  import cpu_isa_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] instr,
  output logic ri
);
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic ok;
  assign op    = instr[OP_HI:OP_LO];
  assign rs    = instr[RS_HI:RS_LO];
  assign rt    = instr[RT_HI:RT_LO];
  assign funct = instr[FN_HI:FN_LO];
  assign ok = (op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_LUI, OP_ORI,
                          OP_ANDI, OP_XORI, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW,
                          OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SH, OP_SB})
           || (op == OP_REGIMM && rt inside {5'd0, 5'd1})
           || (op == OP_COP0 && rs inside {5'd0, 5'd4})
           || (instr == ERET_WORD)
           || (op == OP_SPECIAL && funct inside {FN_JR, FN_JALR, FN_ADDU, FN_SUBU, FN_ADD,
                          FN_SUB, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_AND,
                          FN_OR, FN_NOR, FN_XOR, FN_SLT, FN_SLTU, FN_MULT, FN_MULTU, FN_DIV,
                          FN_DIVU, FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO});
  assign ri = !ok;
endmodule

// File: rtl/id_fetch_buffer.sv
// id_fetch_buffer: DEPTH-entry IF/ID queue presenting the head entry to decode
// with derived PC+4/PC+8 and fetch exceptions merged with reserved-instruction detection.
module id_fetch_buffer
  import cpu_isa_pkg::*;
#(
  parameter int IW = 32,
  parameter int PW = 32,
  parameter int DEPTH = 2,
  parameter int EXW = 5,
  parameter bit RI_EN = 1'b1
) (
  input logic clk,
  input logic reset,
  id_fetch_buffer_if.slave bus
);
  localparam int PTRW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = IW + PW + 1 + EXW;
  logic [EW-1:0] mem [DEPTH];
  logic [PTRW-1:0] rptr;
  logic [PTRW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic valid;
  logic push;
  logic pop;
  logic ri;
  logic [IW-1:0] h_instr;
  logic [PW-1:0] h_pc;
  logic h_bd;
  logic [EXW-1:0] h_exc;
  function automatic logic [PTRW-1:0] inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign valid = cnt != '0;
  assign bus.in_ready = cnt < CW'(DEPTH);
  assign push = bus.in_valid && bus.in_ready;
  assign pop = valid && bus.out_ready;
  always_ff @(posedge clk) begin
    if (!reset || bus.flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= inc(wptr);
      if (pop) rptr <= inc(rptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && reset && !bus.flush) mem[wptr] <= {bus.in_instr, bus.in_pc, bus.in_bd, bus.in_excode};
  end
  // An empty buffer reads as an all-zero entry so decode sees a nop bubble.
  assign {h_instr, h_pc, h_bd, h_exc} = valid ? mem[rptr] : '0;
  ri_decode #(.IW(IW)) u_ri (
    .instr(h_instr),
    .ri(ri)
  );
  assign bus.out_valid = valid;
  assign bus.count = cnt;
  assign bus.IR_D = h_instr;
  assign bus.PC_D = h_pc;
  assign bus.PC4_D = valid ? h_pc + PW'(4) : '0;
  assign bus.PC8_D = valid ? h_pc + PW'(8) : '0;
  assign bus.BD_D = h_bd;
  assign bus.excode_D = (h_exc != '0) ? h_exc
                      : (RI_EN && ri) ? EXW'(EXC_RI) : EXW'(EXC_NONE);
endmodule

// File: tb/tb_id_fetch_buffer.sv
// tb_id_fetch_buffer: directed vector table plus randomized traffic against a queue model
module tb_id_fetch_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, flush, in_valid, in_bd, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0] in_excode;
  int n_chk = 0;
  int n_fail = 0;
  bit armed = 1'b0;

  id_fetch_buffer_if #(.DEPTH(2)) b2 ();
  id_fetch_buffer_if #(.DEPTH(3)) b3 ();
  id_fetch_buffer_if #(.DEPTH(2)) b0 ();
  assign {b2.flush, b2.in_valid, b2.in_instr, b2.in_pc, b2.in_bd, b2.in_excode, b2.out_ready} =
         {flush, in_valid, in_instr, in_pc, in_bd, in_excode, out_ready};
  assign {b3.flush, b3.in_valid, b3.in_instr, b3.in_pc, b3.in_bd, b3.in_excode, b3.out_ready} =
         {flush, in_valid, in_instr, in_pc, in_bd, in_excode, out_ready};
  assign {b0.flush, b0.in_valid, b0.in_instr, b0.in_pc, b0.in_bd, b0.in_excode, b0.out_ready} =
         {flush, in_valid, in_instr, in_pc, in_bd, in_excode, out_ready};
  id_fetch_buffer #(.DEPTH(2), .RI_EN(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  id_fetch_buffer #(.DEPTH(3), .RI_EN(1'b1)) dut3 (.clk(clk), .reset(reset), .bus(b3));
  id_fetch_buffer #(.DEPTH(2), .RI_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", n, $time, a, e);
    end
  endtask

  // Instruction pool with the reserved-instruction verdict read off the supported list by hand.
  typedef struct { logic [31:0] instr; bit ri; } pool_t;
  pool_t pool[18] = '{
    '{32'h3408_0001, 0}, '{32'h8C09_0004, 0}, '{32'hFC00_0000, 1}, '{32'h4200_0018, 0},
    '{32'h4080_6000, 0}, '{32'h0000_003F, 1}, '{32'h0402_0000, 1}, '{32'h0C00_0010, 0},
    '{32'h0000_0021, 0}, '{32'h7C00_0000, 1}, '{32'h4020_0000, 1}, '{32'h0000_0000, 0},
    '{32'h0000_001A, 0}, '{32'h0000_000C, 1}, '{32'h4200_0019, 1}, '{32'h0401_0000, 0},
    '{32'h3C01_0000, 0}, '{32'h2401_0001, 0}};
  function automatic bit pool_ri(input logic [31:0] w);
    foreach (pool[i]) if (pool[i].instr == w) return pool[i].ri;
    return 1'b0;
  endfunction

  typedef struct { logic [31:0] instr, pc; logic bd; logic [4:0] exc; bit ri; } ent_t;
  ent_t mq[3][$];
  int dep[3] = '{2, 3, 2};
  bit rien[3] = '{1, 1, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset || flush) mq[k].delete();
      else begin
        bit pu, po;
        pu = in_valid && mq[k].size() < dep[k];
        po = mq[k].size() > 0 && out_ready;
        if (po) void'(mq[k].pop_front());
        if (pu) mq[k].push_back('{in_instr, in_pc, in_bd, in_excode, pool_ri(in_instr)});
      end
    end
    if (!reset) armed = 1'b1;
  end

  task automatic chk_dut(input string t, input int k, input logic ov, input logic [31:0] cnt,
                         input logic rdy, input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic [31:0] pc8, input logic bd,
                         input logic [4:0] ex);
    ent_t h;
    logic [4:0] e_ex;
    bit v;
    v = mq[k].size() > 0;
    h = v ? mq[k][0] : '{32'h0, 32'h0, 1'b0, 5'd0, 1'b0};
    e_ex = (h.exc != 0) ? h.exc : (rien[k] && h.ri) ? 5'd10 : 5'd0;
    check({t, " out_valid"}, 32'(ov), 32'(v));
    check({t, " count"}, cnt, 32'(mq[k].size()));
    check({t, " in_ready"}, 32'(rdy), 32'(mq[k].size() < dep[k]));
    check({t, " IR_D"}, ir, h.instr);
    check({t, " PC_D"}, pc, h.pc);
    check({t, " PC4_D"}, pc4, v ? h.pc + 32'd4 : 32'd0);
    check({t, " PC8_D"}, pc8, v ? h.pc + 32'd8 : 32'd0);
    check({t, " BD_D"}, 32'(bd), 32'(h.bd));
    check({t, " excode_D"}, 32'(ex), 32'(e_ex));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk_dut("model d2", 0, b2.out_valid, 32'(b2.count), b2.in_ready, b2.IR_D, b2.PC_D,
              b2.PC4_D, b2.PC8_D, b2.BD_D, b2.excode_D);
      chk_dut("model d3", 1, b3.out_valid, 32'(b3.count), b3.in_ready, b3.IR_D, b3.PC_D,
              b3.PC4_D, b3.PC8_D, b3.BD_D, b3.excode_D);
      chk_dut("model d0", 2, b0.out_valid, 32'(b0.count), b0.in_ready, b0.IR_D, b0.PC_D,
              b0.PC4_D, b0.PC8_D, b0.BD_D, b0.excode_D);
      check("d3 count<=3", 32'(b3.count <= 2'd3), 32'd1);
    end
  end

  typedef struct {
    bit rst_n, fl, iv; logic [31:0] instr, pc; bit bd; logic [4:0] exc; bit ordy;
    bit e_ov; int e_cnt; bit e_rdy; logic [31:0] e_ir, e_pc; bit e_bd; logic [4:0] e_ex, e_ex0;
  } vec_t;
  vec_t tv[$];

  initial begin
    {reset, flush, in_valid, in_bd, out_ready, in_instr, in_pc, in_excode} = '0;
    tv = '{
      '{0,0,0,32'h0,32'h0,0,0,0,          0,0,1,32'h0,32'h0,0,0,0},
      '{0,0,0,32'h0,32'h0,0,0,0,          0,0,1,32'h0,32'h0,0,0,0},
      '{1,0,0,32'h0,32'h0,0,0,0,          0,0,1,32'h0,32'h0,0,0,0},
      '{1,0,1,32'h34080001,32'h3000,0,0,0, 1,1,1,32'h34080001,32'h3000,0,0,0},
      '{1,0,1,32'h8C090004,32'h3004,1,0,0, 1,2,0,32'h34080001,32'h3000,0,0,0},
      '{1,0,1,32'hFC000000,32'h3008,0,0,0, 1,2,0,32'h34080001,32'h3000,0,0,0},
      '{1,0,1,32'hFC000000,32'h3008,0,0,1, 1,1,1,32'h8C090004,32'h3004,1,0,0},
      '{1,0,0,32'h0,32'h0,0,0,1,          0,0,1,32'h0,32'h0,0,0,0},
      '{1,0,1,32'h00000021,32'h3010,0,0,0, 1,1,1,32'h00000021,32'h3010,0,0,0},
      '{1,0,1,32'h3C010000,32'h3014,0,0,0, 1,2,0,32'h00000021,32'h3010,0,0,0},
      '{1,1,1,32'h00000021,32'h3018,0,0,1, 0,0,1,32'h0,32'h0,0,0,0},
      '{1,0,0,32'h0,32'h0,0,0,1,          0,0,1,32'h0,32'h0,0,0,0},
      '{1,0,1,32'hFC000000,32'h4000,0,0,0, 1,1,1,32'hFC000000,32'h4000,0,10,0},
      '{1,0,1,32'hFC000000,32'h4004,0,4,1, 1,1,1,32'hFC000000,32'h4004,0,4,4},
      '{1,0,1,32'h42000018,32'h4008,0,0,1, 1,1,1,32'h42000018,32'h4008,0,0,0},
      '{1,0,1,32'h40806000,32'h400C,0,0,1, 1,1,1,32'h40806000,32'h400C,0,0,0},
      '{1,0,1,32'h00000000,32'h4010,0,0,1, 1,1,1,32'h00000000,32'h4010,0,0,0},
      '{1,0,1,32'h0000003F,32'h4014,0,0,1, 1,1,1,32'h0000003F,32'h4014,0,10,0},
      '{1,0,1,32'h04020000,32'h4018,0,0,1, 1,1,1,32'h04020000,32'h4018,0,10,0},
      '{1,0,1,32'h0C000010,32'h401C,0,0,1, 1,1,1,32'h0C000010,32'h401C,0,0,0},
      '{0,0,1,32'h24010001,32'h4020,0,0,1, 0,0,1,32'h0,32'h0,0,0,0},
      '{1,0,1,32'h24010001,32'hFFFFFFFC,1,0,0, 1,1,1,32'h24010001,32'hFFFFFFFC,1,0,0},
      '{1,0,0,32'h0,32'h0,0,0,1,          0,0,1,32'h0,32'h0,0,0,0}};
    foreach (tv[i]) begin
      string s;
      s = $sformatf("vec%0d", i);
      reset = tv[i].rst_n; flush = tv[i].fl; in_valid = tv[i].iv; in_instr = tv[i].instr;
      in_pc = tv[i].pc; in_bd = tv[i].bd; in_excode = tv[i].exc; out_ready = tv[i].ordy;
      @(posedge clk);
      #1;
      check({s, " out_valid"}, 32'(b2.out_valid), 32'(tv[i].e_ov));
      check({s, " count"}, 32'(b2.count), tv[i].e_cnt);
      check({s, " in_ready"}, 32'(b2.in_ready), 32'(tv[i].e_rdy));
      check({s, " IR_D"}, b2.IR_D, tv[i].e_ir);
      check({s, " PC_D"}, b2.PC_D, tv[i].e_pc);
      check({s, " PC4_D"}, b2.PC4_D, tv[i].e_ov ? tv[i].e_pc + 32'd4 : 32'd0);
      check({s, " PC8_D"}, b2.PC8_D, tv[i].e_ov ? tv[i].e_pc + 32'd8 : 32'd0);
      check({s, " BD_D"}, 32'(b2.BD_D), 32'(tv[i].e_bd));
      check({s, " excode_D"}, 32'(b2.excode_D), 32'(tv[i].e_ex));
      check({s, " excode_D RI_EN=0"}, 32'(b0.excode_D), 32'(tv[i].e_ex0));
    end
    for (int c = 0; c < 600; c++) begin
      reset = $urandom_range(0, 149) != 0;
      flush = $urandom_range(0, 29) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      in_instr = pool[$urandom_range(0, 17)].instr;
      in_pc = $urandom & 32'hFFFF_FFFC;
      in_bd = 1'($urandom);
      in_excode = ($urandom_range(0, 3) == 0) ? 5'd4 : 5'd0;
      out_ready = $urandom_range(0, 2) != 0;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
